// File: rtl/mac_unit_pkg.sv
// Shared types for the custom multiply-accumulate unit: core config subset,
// op encoding (Funct3E[1:0]) and FSM states.
package mac_unit_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t MAC_DEFAULT_CFG = '{XLEN: 64};

  typedef enum logic [1:0] {
    MAC_MAC = 2'b00,
    MAC_CLR = 2'b01,
    MAC_RD  = 2'b10,
    MAC_WR  = 2'b11
  } mac_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mac_state_t;

  // MAC and MACCLR run on the iterative engine; everything else is single-cycle.
  function automatic logic isMultiCycle(input logic [2:0] funct3);
    return ~funct3[2] & ~funct3[1];
  endfunction

endpackage

// File: rtl/mac_iter.sv
// Radix-2^ITER shift-add multiplier datapath: operand shifters plus
// partial-product accumulator, advanced one step per enabled cycle.
module mac_iter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ITER = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [XLEN-1:0] prod
);

  logic [XLEN-1:0] a, b, partial;

  // Only the low XLEN bits are kept, so the product is sign-agnostic.
  assign partial = b * {{(XLEN-ITER){1'b0}}, a[ITER-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a    <= '0;
      b    <= '0;
      prod <= '0;
    end else if (load) begin
      a    <= srcA;
      b    <= srcB;
      prod <= '0;
    end else if (en) begin
      prod <= prod + partial;
      a    <= a >> ITER;
      b    <= b << ITER;
    end
  end

endmodule

// File: rtl/mac_unit.sv
// Execute-stage multiply-accumulate unit: FSM, iteration counter, private
// accumulator and the M/W result pipeline feeding the writeback mux.
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter cvw_t        P             = MAC_DEFAULT_CFG,
  parameter int unsigned MAC_ITER_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mac_validE,
  input  logic [2:0]        Funct3E,
  input  logic [P.XLEN-1:0] ForwardedSrcAE,
  input  logic [P.XLEN-1:0] ForwardedSrcBE,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic              StallW,
  input  logic              FlushW,
  output logic              MACStallE,
  output logic              MACValidW,
  output logic [P.XLEN-1:0] MACResultW
);

  localparam int unsigned XLEN = P.XLEN;
  localparam int unsigned N    = XLEN / MAC_ITER_BITS;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;

  mac_state_t      state, nextState;
  mac_op_t         opE;
  logic            multiE, startE, iterEn, commitMultiE, commitSingleE, opClr;
  logic            validE, validM;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc, prod, accNextE, resultE, resultM;

  assign opE    = mac_op_t'(Funct3E[1:0]);
  assign multiE = mac_validE & isMultiCycle(Funct3E);

  // Independent of StallE so the hazard unit sees no combinational loop.
  assign MACStallE = ~reset & multiE & (state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState     = state;
    startE        = 1'b0;
    iterEn        = 1'b0;
    commitMultiE  = 1'b0;
    commitSingleE = 1'b0;
    case (state)
      IDLE: begin
        if (!FlushE) begin
          if (multiE) begin
            startE    = 1'b1;
            nextState = BUSY;
          end else if (mac_validE && !StallE) begin
            commitSingleE = 1'b1;
          end
        end
      end
      BUSY: begin
        if (FlushE) begin
          nextState = IDLE;
        end else begin
          iterEn = 1'b1;
          if (count == CW'(N-1)) nextState = DONE;
        end
      end
      DONE: begin
        if (FlushE) begin
          nextState = IDLE;
        end else if (!StallE) begin
          commitMultiE = 1'b1;
          nextState    = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      opClr <= 1'b0;
    end else if (startE) begin
      count <= '0;
      opClr <= (opE == MAC_CLR);
    end else if (iterEn) begin
      count <= count + 1'b1;
    end
  end

  mac_iter #(
    .XLEN(XLEN),
    .ITER(MAC_ITER_BITS)
  ) iterEngine (
    .clk  (clk),
    .reset(reset),
    .load (startE),
    .en   (iterEn),
    .srcA (ForwardedSrcAE),
    .srcB (ForwardedSrcBE),
    .prod (prod)
  );

  // Reserved encodings commit with a zero result and leave Acc alone.
  always_comb begin
    accNextE = acc;
    resultE  = '0;
    if (commitMultiE) begin
      accNextE = opClr ? prod : acc + prod;
      resultE  = accNextE;
    end else if (commitSingleE && !Funct3E[2]) begin
      case (opE)
        MAC_RD: resultE = acc;
        MAC_WR: begin
          accNextE = ForwardedSrcAE;
          resultE  = ForwardedSrcAE;
        end
        default: ;
      endcase
    end
  end

  assign validE = commitMultiE | commitSingleE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= accNextE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validM  <= 1'b0;
      resultM <= '0;
    end else if (FlushM) begin
      validM  <= 1'b0;
      resultM <= '0;
    end else if (!StallM) begin
      validM  <= validE;
      resultM <= resultE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MACValidW  <= 1'b0;
      MACResultW <= '0;
    end else if (FlushW) begin
      MACValidW  <= 1'b0;
      MACResultW <= '0;
    end else if (!StallW) begin
      MACValidW  <= validM;
      MACResultW <= resultM;
    end
  end

endmodule
